// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking, per-digit enable and blink.
// Segment/anode outputs are registered from next-state values; inputs are captured once per frame.
module seg_scan #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       Clk100M,
   input  logic       reset_n,
   input  logic [7:0] seg0,
   input  logic [7:0] seg1,
   input  logic [7:0] seg2,
   input  logic [7:0] seg3,
   input  logic [3:0] digit_en,
   input  logic [3:0] blink_en,
   input  logic       blink_in,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic       frame_done
);

   localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

   localparam logic [0:0] BLANK = 1'b0;
   localparam logic [0:0] DRIVE = 1'b1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [0:0]    state_q, state_d;
   logic [31:0]   pat_q, pat_d;
   logic [3:0]    en_q, en_d;
   logic          blink_s1_q, blink_s2_q;
   logic [7:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          fd_q, fd_d;
   logic          wrap, snap, dark;

   always_comb begin
      wrap  = (cnt_q == CNT_MAX);
      snap  = wrap && (idx_q == 2'd3);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = wrap ? idx_q + 2'd1 : idx_q;

      state_d = state_q;
      if (wrap)
         state_d = BLANK;
      else if (state_q == BLANK && cnt_d == BLANK_LIM)
         state_d = DRIVE;

      pat_d = pat_q;
      en_d  = en_q;
      if (snap) begin
         pat_d = {seg3, seg2, seg1, seg0};
         en_d  = digit_en;
      end
      fd_d = snap;

      // Outputs are built from the next-cycle view so they line up with cnt_q/idx_q.
      dark  = !en_d[idx_d] || (blink_en[idx_d] && blink_s2_q);
      seg_d = 8'hFF;
      an_d  = 4'hF;
      if (state_d == DRIVE && !dark) begin
         seg_d = pat_d[{idx_d, 3'b000} +: 8];
         an_d  = ~(4'b0001 << idx_d);
      end
   end

   always_ff @(posedge Clk100M or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         state_q    <= BLANK;
         pat_q      <= 32'hFFFF_FFFF;
         en_q       <= 4'b0000;
         blink_s1_q <= 1'b0;
         blink_s2_q <= 1'b0;
         seg_q      <= 8'hFF;
         an_q       <= 4'hF;
         fd_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         state_q    <= state_d;
         pat_q      <= pat_d;
         en_q       <= en_d;
         blink_s1_q <= blink_in;
         blink_s2_q <= blink_s1_q;
         seg_q      <= seg_d;
         an_q       <= an_d;
         fd_q       <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed, table-driven bench for seg_scan at REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_seg_scan;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] s0, s1, s2, s3;
   logic [3:0] den, ben;
   logic       bin;
   logic [7:0] seg;
   logic [3:0] an;
   logic       fd;

   int n_chk  = 0;
   int n_fail = 0;
   int cur_k  = 0;
   logic [7:0] prev_seg = 8'hFF;
   logic [3:0] prev_an  = 4'hF;

   typedef struct {
      logic [7:0]  s0, s1, s2, s3;
      logic [3:0]  en;
      logic [15:0] ean;   // expected anodes, slot i at [4*i +: 4]
      logic [31:0] eseg;  // expected segments, slot i at [8*i +: 8]
   } vec_t;

   vec_t tbl [6];

   seg_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
      .Clk100M(clk), .reset_n(rst_n),
      .seg0(s0), .seg1(s1), .seg2(s2), .seg3(s3),
      .digit_en(den), .blink_en(ben), .blink_in(bin),
      .seg(seg), .an(an), .frame_done(fd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d: got %h, expected %h", nm, cur_k, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      s0 = v.s0; s1 = v.s1; s2 = v.s2; s3 = v.s3; den = v.en;
   endtask

   // Checks frame cycles k0..k1; k=0 is the frame_done cycle (cnt=0, idx=0).
   task automatic check_cycles(input int k0, input int k1, input vec_t e, input bit first);
      logic [3:0] ean;
      logic [7:0] eseg;
      for (int k = k0; k <= k1; k++) begin
         cur_k = k;
         if ((k % 8) < 2) begin
            ean  = 4'hF;
            eseg = 8'hFF;
         end else begin
            ean  = e.ean[(k / 8) * 4 +: 4];
            eseg = e.eseg[(k / 8) * 8 +: 8];
         end
         chk("an", {28'd0, an}, {28'd0, ean});
         chk("seg", {24'd0, seg}, {24'd0, eseg});
         chk("frame_done", {31'd0, fd}, {31'd0, (k == 0) && !first});
         chk("onehot", {31'd0, $countones(~an) <= 1}, 32'd1);
         chk("ghost", {31'd0, (seg == prev_seg) || (prev_an == 4'hF) || (an == 4'hF)}, 32'd1);
         prev_seg = seg;
         prev_an  = an;
         @(negedge clk);
      end
   endtask

   initial begin
      //         s0     s1     s2     s3     en       ean (slot3..0)                         eseg (slot3..0)
      tbl[0] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'hF,    {4'b0111,4'b1011,4'b1101,4'b1110}, {8'hB0,8'hA4,8'hF9,8'hC0}};
      tbl[1] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0101, {4'b1111,4'b1011,4'b1111,4'b1110}, {8'hFF,8'hA4,8'hFF,8'hC0}};
      tbl[2] = '{8'hC0, 8'hF9, 8'h99, 8'hB0, 4'hF,    {4'b0111,4'b1011,4'b1101,4'b1110}, {8'hB0,8'h99,8'hF9,8'hC0}};
      tbl[3] = '{8'h12, 8'h34, 8'h56, 8'h80, 4'b1000, {4'b0111,4'b1111,4'b1111,4'b1111}, {8'h80,8'hFF,8'hFF,8'hFF}};
      tbl[4] = '{8'hC0, 8'hF9, 8'h99, 8'hB0, 4'hF,    {4'b0111,4'b1011,4'b1101,4'b1111}, {8'hB0,8'h99,8'hF9,8'hFF}};
      tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h0,    16'hFFFF,                          32'hFFFF_FFFF};

      rst_n = 1'b0;
      s0 = 8'h00; s1 = 8'h00; s2 = 8'h00; s3 = 8'h00;
      den = 4'h0; ben = 4'h0; bin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_seg", {24'd0, seg}, 32'hFF);
      chk("rst_fd", {31'd0, fd}, 32'd0);

      // First frame after release is dark even though inputs are already valid.
      apply(tbl[0]);
      rst_n = 1'b1;
      check_cycles(0, 31, tbl[5], 1'b1);

      // Each new input set is captured at the next frame boundary.
      for (int i = 1; i <= 3; i++) begin
         apply(tbl[i]);
         check_cycles(0, 31, tbl[i-1], 1'b0);
      end
      apply(tbl[0]);
      check_cycles(0, 31, tbl[3], 1'b0);

      // Mid-frame change of seg2 while idx=1.
      check_cycles(0, 9, tbl[0], 1'b0);
      s2 = 8'h99;
      check_cycles(10, 31, tbl[0], 1'b0);
      check_cycles(0, 31, tbl[2], 1'b0);

      // Blink on digit 0; blink_in toggles in slot 3, 64 cycles apart.
      ben = 4'b0001;
      check_cycles(0, 23, tbl[2], 1'b0);
      bin = 1'b1;
      check_cycles(24, 31, tbl[2], 1'b0);
      check_cycles(0, 31, tbl[4], 1'b0);
      check_cycles(0, 23, tbl[4], 1'b0);
      bin = 1'b0;
      check_cycles(24, 31, tbl[4], 1'b0);
      check_cycles(0, 31, tbl[2], 1'b0);

      // Asynchronous reset between edges at idx=2, cnt=5.
      check_cycles(0, 20, tbl[2], 1'b0);
      cur_k = 21;
      #2;
      chk("pre_rst_an", {28'd0, an}, 32'hB);
      rst_n = 1'b0;
      #1;
      chk("async_an", {28'd0, an}, 32'hF);
      chk("async_seg", {24'd0, seg}, 32'hFF);
      chk("async_fd", {31'd0, fd}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      prev_seg = 8'hFF;
      prev_an  = 4'hF;
      check_cycles(0, 31, tbl[5], 1'b1);
      check_cycles(0, 31, tbl[2], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 ms at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 1000, all-off cycles at the start of each slot; legal range 1 <= BLANK_CYCLES < REFRESH_DIV.
REQ-003 Clk100M  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 seg0, seg1, seg2, seg3  input  8 each  active-low segment patterns {dp,g..a}; seg0 is the rightmost digit.
REQ-006 digit_en  input  4  per-digit enable; bit i gates digit i.
REQ-007 blink_en  input  4  per-digit blink select.
REQ-008 blink_in  input  1  slow asynchronous blink level, e.g. the 1 Hz clock.
REQ-009 seg  output  8  active-low segment drive to the board.
REQ-010 an  output  4  active-low anode drive; bit i selects digit i.
REQ-011 frame_done  output  1  one-cycle pulse when a full 4-digit scan completes.

Function
REQ-012 Counter cnt SHALL run 0..REFRESH_DIV-1 and wrap to 0; each wrap SHALL advance digit index idx 0->1->2->3->0.
REQ-013 The FSM SHALL have two states.
  - BLANK: cnt < BLANK_CYCLES.
  - DRIVE: cnt >= BLANK_CYCLES.
  - BLANK->DRIVE when cnt reaches BLANK_CYCLES; DRIVE->BLANK on wrap.
REQ-014 In BLANK, outputs SHALL be an=4'b1111 and seg=8'hFF.
REQ-015 In DRIVE, an SHALL be low only at bit idx, and seg SHALL equal the snapshot pattern for idx.
REQ-016 The digit SHALL be forced off (an=4'b1111, seg=8'hFF) when either condition holds:
  - the snapshot of digit_en[idx] is 0;
  - blink_en[idx]=1 and the synchronized blink_in is 1.
REQ-017 A forced-off digit SHALL still consume its full slot, so the frame period is always 4*REFRESH_DIV cycles.
REQ-018 seg and an SHALL be registered outputs with no combinational path from any input.
REQ-019 At most one an bit SHALL be low in any cycle.
REQ-020 seg SHALL change only on cycles where an=4'b1111, so there is no ghosting.
REQ-021 seg0..seg3 and digit_en SHALL be snapshotted together on the edge where idx wraps 3->0.
  - Input changes take effect only at the next frame; a frame never mixes old and new values.
REQ-022 blink_in SHALL pass through a 2-flop synchronizer.
  - The synchronized value is sampled live; its latency to the output is 3 cycles or fewer.
REQ-023 frame_done SHALL pulse high for exactly one cycle, on the same edge as the snapshot.
REQ-024 In steady state, digit i SHALL be visibly driven for exactly REFRESH_DIV-BLANK_CYCLES consecutive cycles per frame, preceded by exactly BLANK_CYCLES all-off cycles.

Reset
REQ-025 Asserting reset_n low SHALL set all of the following immediately, with no clock required:
  - an=4'b1111, seg=8'hFF, frame_done=0;
  - cnt=0, idx=0, state=BLANK;
  - snapshot patterns = 8'hFF, snapshot digit_en = 4'b0000;
  - synchronizer flops = 0.
REQ-026 First frame after reset release:
  - no snapshot occurs at release;
  - the first frame displays all-off;
  - the first snapshot occurs at the first 3->0 wrap.
REQ-027 Reset asserted mid-slot or mid-frame SHALL abort the scan; after release, the scan restarts from idx=0, cnt=0 in BLANK.

Verification
(Scenarios 1-5 use REFRESH_DIV=8, BLANK_CYCLES=2.)
REQ-028 Basic scan. Stimulus: reset, then seg0..3=8'hC0,8'hF9,8'hA4,8'hB0 and digit_en=4'hF, blink_en=0.
  - After the first frame_done, expect the repeating pattern: 2 cycles an=1111/seg=FF, then 6 cycles an=1110/seg=C0.
  - The same follows for an=1101/F9, 1011/A4, 0111/B0, with period 32 cycles.
REQ-029 Mid-frame update. Change seg2 to 8'h99 while idx=1.
  - The current frame still shows A4 on digit 2; the next frame shows 99.
  - frame_done pulses exactly once per 32 cycles.
REQ-030 Digit disable. digit_en=4'b0101.
  - Slots 1 and 3 stay an=1111/seg=FF for their full 8 cycles; the frame period remains 32.
REQ-031 Blink. blink_en=4'b0001, blink_in toggling every 64 cycles.
  - Digit 0 is dark while synchronized blink_in=1; digits 1-3 are unaffected.
  - The checker asserts the one-hot/blank invariants (REQ-019, REQ-020) every cycle.
REQ-032 Async reset mid-DRIVE. Assert reset_n=0 at idx=2, cnt=5, between clock edges.
  - an=1111, seg=FF, frame_done=0 appear before the next edge.
  - After release, the first 32-cycle frame is all-off.
REQ-033 Defaults. With REFRESH_DIV=100000, BLANK_CYCLES=1000:
  - each digit is active for 99000 cycles;
  - frame_done period is 400000 cycles.
